// File: rtl/debounce_pkg.sv
// Shared types for the time-shared debounce controller: FSM states and the counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } state_t;

  // Wide enough to hold N; the count itself never exceeds N-1.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_eval_engine.sv
// Combinational compare/count step for one channel; zero latency, no flow control.
module debounce_eval_engine
  import debounce_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cnt_width(N)
) (
  input  logic          sample,
  input  logic          stable,
  input  logic [CW-1:0] cnt,
  output logic [CW-1:0] next_cnt,
  output logic          next_stable,
  output logic          accept,
  output logic          rise,
  output logic          fall
);

  always_comb begin
    next_cnt    = '0;
    next_stable = stable;
    accept      = 1'b0;
    rise        = 1'b0;
    fall        = 1'b0;
    if (sample != stable) begin
      if (cnt == CW'(N - 1)) begin
        accept      = 1'b1;
        next_stable = sample;
        rise        = sample;
        fall        = ~sample;
      end else begin
        next_cnt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debouncer: one channel evaluated per PRESCALE+1 cycle slot.
// Acceptance within 2 + N*NUM_CH*(PRESCALE+1) cycles; scan_en=0 parks the scan, state retained.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int N        = 4,
  parameter  int PRESCALE = 16,
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] noisy_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [CHW-1:0]    cur_ch,
  output logic              busy
);

  localparam int CW = cnt_width(N);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] stable;
  logic [CW-1:0]     cnt [NUM_CH];

  logic [CW-1:0]     nxt_cnt;
  logic              nxt_stable;
  logic              accept;
  logic              rise;
  logic              fall;

  debounce_eval_engine #(.N(N), .CW(CW)) u_eval (
    .sample      (sync2[cur_ch]),
    .stable      (stable[cur_ch]),
    .cnt         (cnt[cur_ch]),
    .next_cnt    (nxt_cnt),
    .next_stable (nxt_stable),
    .accept      (accept),
    .rise        (rise),
    .fall        (fall)
  );

  // The stable array is the registered debounced level.
  assign clean_out = stable;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      cur_ch     <= '0;
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= noisy_in;
      sync2      <= sync1;
      rise_pulse <= '0;
      fall_pulse <= '0;
      case (state)
        IDLE: begin
          presc <= '0;
          if (scan_en) state <= WAIT;
        end
        WAIT: begin
          if (!scan_en) begin
            state <= IDLE;
            presc <= '0;
          end else if (presc == PW'(PRESCALE - 1)) begin
            presc <= '0;
            state <= EVAL;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        EVAL: begin
          cnt[cur_ch]    <= nxt_cnt;
          stable[cur_ch] <= nxt_stable;
          if (accept) begin
            rise_pulse[cur_ch] <= rise;
            fall_pulse[cur_ch] <= fall;
          end
          cur_ch <= (cur_ch == CHW'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
          state  <= scan_en ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: two configurations against a slot-level reference model.
module tb_debounce_scan_ctrl;

  localparam int NC = 4;
  localparam int NPA [2] = '{4, 1};
  localparam int PPA [2] = '{2, 1};

  logic       clk = 1'b0;
  logic       rst     [2];
  logic       scan_en [2];
  logic [3:0] noisy   [2];
  logic [3:0] clean   [2];
  logic [3:0] rise    [2];
  logic [3:0] fall    [2];
  logic [1:0] cur     [2];
  logic       busy    [2];

  always #5 clk = ~clk;

  debounce_scan_ctrl #(.NUM_CH(4), .N(4), .PRESCALE(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .scan_en(scan_en[0]), .noisy_in(noisy[0]),
    .clean_out(clean[0]), .rise_pulse(rise[0]), .fall_pulse(fall[0]),
    .cur_ch(cur[0]), .busy(busy[0])
  );

  debounce_scan_ctrl #(.NUM_CH(4), .N(1), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .scan_en(scan_en[1]), .noisy_in(noisy[1]),
    .clean_out(clean[1]), .rise_pulse(rise[1]), .fall_pulse(fall[1]),
    .cur_ch(cur[1]), .busy(busy[1])
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting (m_left cycles to go), 2 evaluating m_ch.
  int         m_phase [2];
  int         m_left  [2];
  int         m_ch    [2];
  int         m_cnt   [2][NC];
  logic [3:0] m_stab  [2];
  logic [3:0] m_rise  [2];
  logic [3:0] m_fall  [2];
  logic [3:0] m_s1    [2];
  logic [3:0] m_s2    [2];

  task automatic model_step(input int k);
    logic [3:0] s;
    int c;
    s = m_s2[k];
    if (rst[k]) begin
      m_phase[k] = 0; m_left[k] = 0; m_ch[k] = 0;
      m_stab[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
      m_s1[k] = '0; m_s2[k] = '0;
      for (int i = 0; i < NC; i++) m_cnt[k][i] = 0;
      return;
    end
    m_s2[k] = m_s1[k];
    m_s1[k] = noisy[k];
    m_rise[k] = '0;
    m_fall[k] = '0;
    case (m_phase[k])
      0: if (scan_en[k]) begin m_phase[k] = 1; m_left[k] = PPA[k]; end
      1: begin
        if (!scan_en[k]) m_phase[k] = 0;
        else begin
          m_left[k]--;
          if (m_left[k] == 0) m_phase[k] = 2;
        end
      end
      default: begin
        c = m_ch[k];
        if (s[c] == m_stab[k][c]) m_cnt[k][c] = 0;
        else if (m_cnt[k][c] + 1 == NPA[k]) begin
          m_stab[k][c] = s[c];
          m_cnt[k][c] = 0;
          if (s[c]) m_rise[k][c] = 1'b1;
          else      m_fall[k][c] = 1'b1;
        end else m_cnt[k][c]++;
        m_ch[k] = (c + 1) % NC;
        if (scan_en[k]) begin m_phase[k] = 1; m_left[k] = PPA[k]; end
        else m_phase[k] = 0;
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("i%0d_clean", k), clean[k], m_stab[k]);
        chk($sformatf("i%0d_rise", k), rise[k], m_rise[k]);
        chk($sformatf("i%0d_fall", k), fall[k], m_fall[k]);
        chk($sformatf("i%0d_cur", k), cur[k], m_ch[k]);
        chk($sformatf("i%0d_busy", k), busy[k], m_phase[k] != 0);
      end
    end
  end

  task automatic wait_clean(input int k, input int b, input logic v, input string nm,
                            output int np);
    int cyc;
    cyc = 0;
    np = 0;
    while (clean[k][b] !== v && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (rise[k][b] | fall[k][b]) np++;
    end
    chk({nm, "_in_time"}, cyc <= 50, 1);
    repeat (4) begin
      @(negedge clk);
      if (rise[k][b] | fall[k][b]) np++;
    end
  endtask

  initial begin
    int np;
    int t;
    int saved;
    logic c8;
    logic c9;

    rst = '{1'b1, 1'b1};
    scan_en = '{1'b0, 1'b0};
    noisy = '{4'h0, 4'h0};
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_clean", clean[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_cur", cur[0], 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Test 1: scan order and slot timing with quiet inputs.
    scan_en[0] = 1'b1;
    @(negedge clk);
    chk("t1_busy", busy[0], 1);
    for (int j = 1; j <= 4; j++) begin
      repeat (3) @(negedge clk);
      chk($sformatf("t1_cur_step%0d", j), cur[0], j % 4);
    end
    chk("t1_clean", clean[0], 0);

    // Test 2: held level on channel 2 gets accepted with one rise pulse.
    noisy[0][2] = 1'b1;
    wait_clean(0, 2, 1'b1, "t2", np);
    chk("t2_pulses", np, 1);
    chk("t2_clean", clean[0], 4'b0100);

    // Test 3: glitch on channel 1 lasting three evaluations.
    t = 0;
    while (!(m_phase[0] == 2 && m_ch[0] == 1) && t < 100) begin @(negedge clk); t++; end
    chk("t3_sync", t < 100, 1);
    @(negedge clk);
    noisy[0][1] = 1'b1;
    repeat (36) @(negedge clk);
    noisy[0][1] = 1'b0;
    chk("t3_model_cnt", m_cnt[0][1], 3);
    repeat (14) @(negedge clk);
    chk("t3_cnt_clear", m_cnt[0][1], 0);
    chk("t3_clean", clean[0], 4'b0100);

    // Test 4: channel 0 accepted high, then low with a single fall pulse.
    noisy[0][0] = 1'b1;
    wait_clean(0, 0, 1'b1, "t4_up", np);
    noisy[0][0] = 1'b0;
    wait_clean(0, 0, 1'b0, "t4_down", np);
    chk("t4_fall_pulses", np, 1);
    chk("t4_clean", clean[0], 4'b0100);

    // Test 5: park during WAIT with a partial count on channel 3.
    noisy[0][3] = 1'b1;
    t = 0;
    while (!(m_cnt[0][3] == 1 && m_phase[0] == 1) && t < 100) begin @(negedge clk); t++; end
    chk("t5_sync", t < 100, 1);
    scan_en[0] = 1'b0;
    saved = m_ch[0];
    @(negedge clk);
    chk("t5_busy_off", busy[0], 0);
    repeat (20) @(negedge clk);
    chk("t5_cur_kept", cur[0], saved);
    scan_en[0] = 1'b1;
    @(negedge clk);
    chk("t5_busy_on", busy[0], 1);
    wait_clean(0, 3, 1'b1, "t5", np);
    chk("t5_clean", clean[0], 4'b1100);

    // Test 6: N=1, PRESCALE=1, reset mid-scan.
    scan_en[1] = 1'b1;
    repeat (10) @(negedge clk);
    noisy[1][3] = 1'b1;
    repeat (3) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("t6_rst_clean", clean[1], 0);
    chk("t6_rst_cur", cur[1], 0);
    chk("t6_rst_busy", busy[1], 0);
    chk("t6_rst_pulses", {rise[1], fall[1]}, 0);
    rst[1] = 1'b0;
    c8 = 1'b0;
    c9 = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 8) c8 = clean[1][3];
      if (j == 9) c9 = clean[1][3];
    end
    chk("t6_before_eval3", c8, 0);
    chk("t6_first_eval3", c9, 1);

    // Randomized soak on both configurations.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 11) == 0) noisy[k][$urandom_range(0, 3)] ^= 1'b1;
        if (scan_en[k]) begin
          if ($urandom_range(0, 199) == 0) scan_en[k] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) scan_en[k] = 1'b1;
        rst[k] = ($urandom_range(0, 599) == 0);
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
